cdc_req_sender: RTL

Source-domain end of the team's toggle-based request/acknowledge clock-domain crossing. The block accepts a data word with a valid/ready handshake and latches it into a hold register that stays stable for the whole transfer. It announces the word by toggling a request line, then waits for the destination's acknowledge toggle, which it synchronizes internally before accepting the next word. It sits in the sending clock domain, opposite the destination-side multi-flop synchronizer and capture logic.

---
 rtl/cdc_req_sender_pkg.sv | 10 +
 rtl/bit_synchronizer.sv | 32 +++
 rtl/cdc_req_sender.sv | 99 +++++++++
 3 files changed

// File: rtl/cdc_req_sender_pkg.sv
// Shared constants for the source side of the toggle request/acknowledge crossing.
// Holds the sender FSM encoding and the minimum acknowledge synchronizer depth.
package cdc_req_sender_pkg;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_ACK = 1'b1;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for quasi-static or toggle signals entering the clk domain.
// Only the first flop samples the asynchronous input.
module bit_synchronizer
  import cdc_req_sender_pkg::*;
#(
  parameter int unsigned width      = 1,
  parameter int unsigned num_stages = MIN_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] sync_q [num_stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(num_stages); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(num_stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[num_stages-1];

endmodule

// File: rtl/cdc_req_sender.sv
// Source-domain end of the toggle req/ack crossing: holds a word, toggles REQ_TGL,
// and waits for the synchronized ACK_TGL to match before accepting the next word.
module cdc_req_sender
  import cdc_req_sender_pkg::*;
#(
  parameter int unsigned width      = 8,
  parameter int unsigned num_stages = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [width-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [width-1:0] TX_DATA,
  output logic             REQ_TGL,
  input  logic             ACK_TGL,
  output logic             DONE,
  output logic             PROTO_ERR,
  output logic [0:0]       dbg_state_o
);

  // Handshake: a word moves when IN_VALID && IN_READY at a rising clk edge;
  // IN_READY depends on the state register only, never on IN_VALID.

  localparam int unsigned SYNC_DEPTH =
    (num_stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : num_stages;

  logic [0:0]       state_q, state_d;
  logic [width-1:0] tx_data_q, tx_data_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_prev_q;
  logic [0:0]       ack_sync_vec;
  logic             ack_sync;

  bit_synchronizer #(
    .width      (1),
    .num_stages (SYNC_DEPTH)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (RST),
    .d_i   (ACK_TGL),
    .q_o   (ack_sync_vec)
  );

  assign ack_sync = ack_sync_vec[0];

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    req_d     = req_q;
    done_d    = 1'b0;
    // Any movement of the acknowledge while nothing is outstanding is a protocol fault.
    err_d     = err_q | ((state_q == ST_IDLE) && (ack_sync != ack_prev_q));
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          tx_data_d = IN_DATA;
          req_d     = ~req_q;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sync == req_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      req_q      <= req_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_prev_q <= ack_sync;
    end
  end

  assign IN_READY    = (state_q == ST_IDLE);
  assign TX_DATA     = tx_data_q;
  assign REQ_TGL     = req_q;
  assign DONE        = done_q;
  assign PROTO_ERR   = err_q;
  assign dbg_state_o = state_q;

endmodule
